servant_uart_rx: RTL and testbench
==================================

SERVANT_UART_RX -- requirements
Module: servant_uart_rx

Interface
REQ-001 SHALL have parameter clks_per_bit, default 16, wb_clk cycles per serial bit; legal values are >= 4.
REQ-002 SHALL have port wb_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port wb_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_rx  input  1  asynchronous serial line (the servant q/GPIO UART stream), idle high, 8N1, LSB first.
REQ-005 SHALL have port i_ready  input  1  consumer accepts o_data when o_valid & i_ready.
REQ-006 SHALL have port o_data  output  8  received byte.
REQ-007 SHALL have port o_valid  output  1  o_data holds an unaccepted byte.
REQ-008 SHALL have port o_frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 SHALL have port o_overrun  output  1  one-cycle pulse, completed byte dropped.
REQ-010 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL pass i_rx through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rx_s.
REQ-012 SHALL implement the states IDLE, START, DATA, STOP and BREAK.
REQ-013 IDLE: on rx_s == 0, SHALL enter START and load the bit counter with clks_per_bit/2 - 1 (integer division).
REQ-014 Counter SHALL decrement each cycle; a "sample" SHALL occur in the cycle the counter equals 0, at which point it reloads with clks_per_bit - 1.
REQ-015 START sample: rx_s == 1 SHALL return to IDLE with no output (glitch reject); rx_s == 0 SHALL enter DATA with bit index 0.
REQ-016 DATA: each sample SHALL shift rx_s into bit [index] of the shift register; after index 7, SHALL enter STOP.
REQ-017 STOP sample with rx_s == 1 SHALL deliver the byte per REQ-019 and enter IDLE in the next cycle.
REQ-018 STOP sample with rx_s == 0 SHALL pulse o_frame_err for 1 cycle, discard the byte and enter BREAK; BREAK SHALL exit to IDLE on the first cycle rx_s == 1.
REQ-019 Delivery: if o_valid == 0, or o_valid & i_ready in the same cycle, o_data SHALL load the byte and o_valid SHALL be 1 in the next cycle.
REQ-020 Delivery with o_valid == 1 and i_ready == 0: o_data SHALL keep the old byte, the new byte SHALL be dropped, and o_overrun SHALL pulse 1 cycle.
REQ-021 o_valid & i_ready with no delivery in that cycle SHALL clear o_valid next cycle; o_data SHALL hold its value.
REQ-022 o_data SHALL change only on delivery (stable while o_valid is high).
REQ-023 Latency: o_valid SHALL rise exactly 1 cycle after the STOP sample cycle; start-edge-to-valid SHALL be 2 synchronizer cycles + 1 + clks_per_bit/2 + 9*clks_per_bit + 1.
REQ-024 i_ready while o_valid == 0 SHALL have no effect.
REQ-025 A new start bit arriving immediately after STOP (rx_s low in the first IDLE cycle) SHALL be detected; back-to-back frames SHALL NOT be lost.

Reset
REQ-026 While wb_rst is high in any state (mid-frame included), the block SHALL on the next edge enter IDLE with o_data = 0x00, o_valid = 0, o_frame_err = 0, o_overrun = 0, o_busy = 0, counter = 0, bit index = 0, and both synchronizer flops = 1.
REQ-027 A partially received frame SHALL be discarded by reset; after reset deasserts, the block SHALL wait for the next falling edge.

Verification (clks_per_bit = 16)
REQ-028 Send 0x55 8N1 with i_ready = 0 -> o_valid rises and o_data = 0x55 stays stable; pulse i_ready for 1 cycle -> o_valid = 0 next cycle.
REQ-029 Drive i_rx low for 4 cycles, then high -> no o_valid, o_busy returns to 0 within 8 + 3 cycles, no error pulses.
REQ-030 Send 0xA5 with stop bit = 0, held low 40 cycles -> single o_frame_err pulse, o_valid stays 0, o_busy stays 1 until the line goes high; next frame 0x3C is received correctly.
REQ-031 Send back-to-back 0x12, 0x34 with i_ready = 0 -> o_data = 0x12 and one o_overrun pulse at the second STOP sample; repeat with i_ready = 1 -> consumer sees 0x12 then 0x34, no overrun.
REQ-032 Assert wb_rst for 1 cycle in the middle of DATA bit 3 -> all outputs 0 next cycle, no delivery of the aborted frame; next frame 0x7E gives o_data = 0x7E.
REQ-033 The bench SHALL check the REQ-023 latency value exactly on every received byte.

Source files
------------

// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling and a
// single-entry valid/ready output buffer that reports framing errors and overruns.
module servant_uart_rx #(
  parameter int unsigned clks_per_bit = 16
) (
  input  logic       wb_clk,
  input  logic       wb_rst,
  input  logic       i_rx,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int unsigned CntW = $clog2(clks_per_bit);
  localparam logic [CntW-1:0] HalfLoad = CntW'(clks_per_bit / 2 - 1);
  localparam logic [CntW-1:0] BitLoad  = CntW'(clks_per_bit - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            sample;
  logic            deliver;

  assign sample = (cnt_q == '0);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    deliver = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
        end
      end
      StStart: begin
        if (sample) begin
          cnt_d = BitLoad;
          if (rx_s_q) begin
            state_d = StIdle;  // glitch shorter than half a bit
          end else begin
            state_d = StData;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StData: begin
        if (sample) begin
          cnt_d          = BitLoad;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStop: begin
        if (sample) begin
          cnt_d = BitLoad;
          if (rx_s_q) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StBreak: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output buffer: a new byte is only taken if the slot is empty or drains this cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (deliver) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_servant_uart_rx.sv
// Scoreboard bench for servant_uart_rx: directed scenarios plus a randomized frame
// stream, with a forked monitor that checks every presented byte and its latency.
module tb_servant_uart_rx;

  localparam int unsigned Cpb = 16;
  // Cycles counted inclusively from the cycle the line falls to the first valid cycle.
  localparam int Lat = 2 + 1 + Cpb / 2 + 9 * Cpb + 1;

  logic       wb_clk  = 1'b0;
  logic       wb_rst  = 1'b1;
  logic       i_rx    = 1'b1;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  int cyc = 0;

  always #5 wb_clk = ~wb_clk;
  always @(posedge wb_clk) cyc <= cyc + 1;

  servant_uart_rx #(
    .clks_per_bit(Cpb)
  ) dut (
    .wb_clk     (wb_clk),
    .wb_rst     (wb_rst),
    .i_rx       (i_rx),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ferr_cnt = 0;
  int   ovr_cnt = 0;
  int   ovr_cyc = -1;
  int   rx_cnt = 0;
  int   last_start = 0;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge wb_clk);
    #1;
    if (rand_ready) i_ready = 1'($urandom_range(0, 1));
  endtask

  // Start bit plus eight data bits; the caller drives the stop bit.
  task automatic send_bits(input logic [7:0] d, input bit expect_byte);
    exp_t e;
    i_rx       = 1'b0;
    last_start = cyc;
    if (expect_byte) begin
      e.data  = d;
      e.start = cyc;
      sb_q.push_back(e);
    end
    repeat (Cpb) tick();
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      repeat (Cpb) tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit expect_byte);
    send_bits(d, expect_byte);
    i_rx = 1'b1;
    repeat (Cpb) tick();
  endtask

  task automatic monitor;
    logic       pv = 1'b0;
    logic       phs = 1'b0;
    logic       pf = 1'b0;
    logic       po = 1'b0;
    logic [7:0] pd = '0;
    exp_t       e;
    forever begin
      @(negedge wb_clk);
      if (o_valid && !(pv && !phs)) begin
        rx_cnt++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_byte: got 0x%02h, no byte expected (cycle %0d)", o_data, cyc);
        end else begin
          e = sb_q.pop_front();
          check("rx_data", int'(o_data), int'(e.data));
          check("latency", cyc - e.start + 1, Lat);
        end
      end
      if (pv && !phs && o_valid) check("data_stable", int'(o_data), int'(pd));
      if (o_frame_err) begin
        ferr_cnt++;
        check("ferr_width", int'(pf), 0);
      end
      if (o_overrun) begin
        ovr_cnt++;
        ovr_cyc = cyc;
        check("ovr_width", int'(po), 0);
      end
      pv  = o_valid;
      phs = o_valid && i_ready;
      pd  = o_data;
      pf  = o_frame_err;
      po  = o_overrun;
    end
  endtask

  initial begin
    int f0, o0, r0, k, busy_low, ferr_exp, sel;
    fork
      monitor();
      begin
        #2000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
      end
    join_none

    wb_rst = 1'b1;
    repeat (3) tick();
    check("rst_valid", int'(o_valid), 0);
    check("rst_data", int'(o_data), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_ferr", int'(o_frame_err), 0);
    wb_rst = 1'b0;
    repeat (5) tick();

    // Byte held with no consumer, then a single-cycle accept.
    i_ready = 1'b0;
    send_frame(8'h55, 1'b1);
    repeat (20) tick();
    check("hold_valid", int'(o_valid), 1);
    check("hold_data", int'(o_data), 8'h55);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("accept_clears_valid", int'(o_valid), 0);
    check("accept_keeps_data", int'(o_data), 8'h55);
    repeat (5) tick();

    // Short low glitch must be rejected silently.
    f0 = ferr_cnt; o0 = ovr_cnt; r0 = rx_cnt;
    i_rx = 1'b0;
    repeat (4) tick();
    i_rx = 1'b1;
    check("glitch_busy", int'(o_busy), 1);
    for (k = 0; k < 11 && o_busy; k++) tick();
    check("glitch_busy_clear", int'(o_busy), 0);
    repeat (20) tick();
    check("glitch_no_byte", rx_cnt, r0);
    check("glitch_no_ferr", ferr_cnt, f0);
    check("glitch_no_ovr", ovr_cnt, o0);

    // Stop bit low then a long break; the next frame must still be received.
    i_ready = 1'b1;
    send_bits(8'hA5, 1'b0);
    i_rx = 1'b0;
    busy_low = 0;
    repeat (40) begin
      tick();
      if (!o_busy) busy_low++;
    end
    check("break_busy_held", busy_low, 0);
    check("break_ferr_once", ferr_cnt, f0 + 1);
    check("break_no_valid", int'(o_valid), 0);
    i_rx = 1'b1;
    for (k = 0; k < 4 && o_busy; k++) tick();
    check("break_exit", int'(o_busy), 0);
    check("break_no_byte", rx_cnt, r0);
    repeat (3) tick();
    send_frame(8'h3C, 1'b1);
    repeat (5) tick();
    check("after_break_data", int'(o_data), 8'h3C);

    // Back-to-back frames with the buffer full: second byte dropped with an overrun.
    i_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b0);
    repeat (5) tick();
    check("ovr_once", ovr_cnt, o0 + 1);
    check("ovr_timing", ovr_cyc - last_start + 1, Lat);
    check("ovr_keeps_data", int'(o_data), 8'h12);
    check("ovr_keeps_valid", int'(o_valid), 1);
    i_ready = 1'b1;
    repeat (4) tick();
    o0 = ovr_cnt;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    repeat (5) tick();
    check("b2b_no_ovr", ovr_cnt, o0);
    check("b2b_last_data", int'(o_data), 8'h34);

    // Reset in the middle of data bit 3 with a byte still pending.
    i_ready = 1'b0;
    send_frame(8'h81, 1'b1);
    repeat (3) tick();
    i_rx = 1'b0;
    repeat (Cpb) tick();
    for (int i = 0; i < 3; i++) begin
      i_rx = 1'b1 & (8'hF9 >> i);
      repeat (Cpb) tick();
    end
    i_rx = 1'b1;
    repeat (Cpb / 2) tick();
    wb_rst = 1'b1;
    tick();
    wb_rst = 1'b0;
    check("midrst_valid", int'(o_valid), 0);
    check("midrst_data", int'(o_data), 0);
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_ferr", int'(o_frame_err), 0);
    check("midrst_ovr", int'(o_overrun), 0);
    r0 = rx_cnt;
    repeat (Cpb / 2 + 5 * Cpb + 10) tick();
    check("midrst_no_byte", rx_cnt, r0);
    i_ready = 1'b1;
    send_frame(8'h7E, 1'b1);
    repeat (5) tick();
    check("after_rst_data", int'(o_data), 8'h7E);

    // Random stream: good frames, glitches and broken stop bits, random consumer.
    rand_ready = 1'b1;
    f0 = ferr_cnt; o0 = ovr_cnt;
    ferr_exp = 0;
    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        i_rx = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        i_rx = 1'b1;
        repeat (14) tick();
      end else if (sel == 1) begin
        send_bits(8'($urandom), 1'b0);
        i_rx = 1'b0;
        repeat ($urandom_range(Cpb, 3 * Cpb)) tick();
        i_rx = 1'b1;
        repeat (4) tick();
        ferr_exp++;
      end else begin
        send_frame(8'($urandom), 1'b1);
      end
      repeat ($urandom_range(0, 20)) tick();
    end
    rand_ready = 1'b0;
    i_ready = 1'b1;
    repeat (40) tick();
    check("sb_drained", sb_q.size(), 0);
    check("rand_ferr_count", ferr_cnt - f0, ferr_exp);
    check("rand_no_ovr", ovr_cnt - o0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
